// File: rtl/mem_stage.sv
// Memory-access pipeline stage: registers the EX->MEM bus and merges load data from the data SRAM.
// Latency: 1 cycle (bus capture to mem_to_wb_bus). Backpressure: stall[3]/stall[4] hold or bubble the stage.
// Optional macro MEM_FWD_EN adds the MEM->decode forwarding outputs.
module mem_stage #(
  parameter int STALL_W      = 6,
  parameter int EX_TO_MEM_WD = 76,
  parameter int MEM_TO_WB_WD = 70
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic [STALL_W-1:0]      stall,
  input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  input  logic [31:0]             data_sram_rdata,
  output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
  output logic                    mem_busy
`ifdef MEM_FWD_EN
  ,
  output logic                    mem_fwd_we,
  output logic [4:0]              mem_fwd_waddr,
  output logic [31:0]             mem_fwd_wdata
`endif
);

  typedef enum logic {FRESH = 1'b0, HELD = 1'b1} state_t;

  state_t                  state, state_nxt;
  logic [EX_TO_MEM_WD-1:0] bus_r;
  logic [31:0]             rdata_buf;
  logic [31:0]             load_data;

  logic [31:0] pc;
  logic        data_ram_en;
  logic [3:0]  data_ram_wen;
  logic        sel_rf_res;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] ex_result;
  logic [31:0] rf_wdata;
  logic        is_load;

  logic bubble;
  logic bus_keep;
  logic unused_stall;

  assign bubble       = stall[3] & ~stall[4];
  // Only this combination leaves bus_r untouched on the edge; everything else rewrites it.
  assign bus_keep     = ~flush & stall[3] & stall[4];
  assign unused_stall = ^{stall[STALL_W-1:5], stall[2:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_r <= '0;
    end else if (flush || bubble) begin
      bus_r <= '0;
    end else if (!stall[3]) begin
      bus_r <= ex_to_mem_bus;
    end
  end

  assign pc           = bus_r[75:44];
  assign data_ram_en  = bus_r[43];
  assign data_ram_wen = bus_r[42:39];
  assign sel_rf_res   = bus_r[38];
  assign rf_we        = bus_r[37];
  assign rf_waddr     = bus_r[36:32];
  assign ex_result    = bus_r[31:0];

  assign is_load = data_ram_en & (data_ram_wen == 4'b0000) & sel_rf_res;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FRESH;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = FRESH;
    if (bus_keep && (state == HELD || is_load)) begin
      state_nxt = HELD;
    end
  end

  // SRAM data is only valid in the first MEM cycle, so grab it on the edge that starts the hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_buf <= '0;
    end else if (bus_keep && state == FRESH && is_load) begin
      rdata_buf <= data_sram_rdata;
    end
  end

  always_comb begin
    mem_busy  = 1'b0;
    load_data = data_sram_rdata;
    if (state == HELD) begin
      mem_busy  = 1'b1;
      load_data = rdata_buf;
    end
  end

  assign rf_wdata      = sel_rf_res ? load_data : ex_result;
  assign mem_to_wb_bus = {pc, rf_we, rf_waddr, rf_wdata};

`ifdef MEM_FWD_EN
  logic bus_vld;
  assign bus_vld       = |bus_r;
  assign mem_fwd_we    = bus_vld & rf_we;
  assign mem_fwd_waddr = bus_vld ? rf_waddr : 5'd0;
  assign mem_fwd_wdata = bus_vld ? rf_wdata : 32'd0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: stimulus pushes expected per-cycle outputs, a monitor pops and compares.
module tb_mem_stage;

  localparam logic [5:0] ST_RUN  = 6'b000000;
  localparam logic [5:0] ST_HOLD = 6'b011000;
  localparam logic [5:0] ST_BUB  = 6'b001000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic [5:0]  stall = '0;
  logic [75:0] ex_to_mem_bus = '0;
  logic [31:0] data_sram_rdata = '0;
  logic [69:0] mem_to_wb_bus;
  logic        mem_busy;
`ifdef MEM_FWD_EN
  logic        mem_fwd_we;
  logic [4:0]  mem_fwd_waddr;
  logic [31:0] mem_fwd_wdata;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    string       name;
    logic [69:0] bus;
    logic        busy;
  } exp_t;

  exp_t sb[$];

  mem_stage dut (
    .clk             (clk),
    .rst             (rst),
    .flush           (flush),
    .stall           (stall),
    .ex_to_mem_bus   (ex_to_mem_bus),
    .data_sram_rdata (data_sram_rdata),
    .mem_to_wb_bus   (mem_to_wb_bus),
    .mem_busy        (mem_busy)
`ifdef MEM_FWD_EN
    ,
    .mem_fwd_we      (mem_fwd_we),
    .mem_fwd_waddr   (mem_fwd_waddr),
    .mem_fwd_wdata   (mem_fwd_wdata)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [75:0] ex_bus(input logic [31:0] pc, input logic en, input logic [3:0] wen,
                                         input logic sel, input logic we, input logic [4:0] wa,
                                         input logic [31:0] res);
    return {pc, en, wen, sel, we, wa, res};
  endfunction

  function automatic logic [69:0] wb_bus(input logic [31:0] pc, input logic we, input logic [4:0] wa,
                                         input logic [31:0] wd);
    return {pc, we, wa, wd};
  endfunction

  // One cycle: after the edge, drive this cycle's inputs and record what the output must be now.
  task automatic step(input logic r, input logic f, input logic [5:0] st, input logic [75:0] bus_in,
                      input logic [31:0] rdata, input string nm, input logic [69:0] exp_bus,
                      input logic exp_busy);
    exp_t e;
    @(posedge clk);
    #1;
    rst             = r;
    flush           = f;
    stall           = st;
    ex_to_mem_bus   = bus_in;
    data_sram_rdata = rdata;
    e.name = nm;
    e.bus  = exp_bus;
    e.busy = exp_busy;
    sb.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_checks++;
        if (mem_to_wb_bus === e.bus) n_pass++;
        else $display("FAIL %s.bus actual=%h expected=%h", e.name, mem_to_wb_bus, e.bus);
        n_checks++;
        if (mem_busy === e.busy) n_pass++;
        else $display("FAIL %s.busy actual=%b expected=%b", e.name, mem_busy, e.busy);
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [75:0] alu1, ld1, ld2, st1, ld3, alu2, alu3, ld4, ld5, alu4;
    alu1 = ex_bus(32'hBFC00010, 1'b0, 4'h0, 1'b0, 1'b1, 5'd5,  32'h12345678);
    ld1  = ex_bus(32'hBFC00014, 1'b1, 4'h0, 1'b1, 1'b1, 5'd8,  32'h80001000);
    ld2  = ex_bus(32'hBFC00018, 1'b1, 4'h0, 1'b1, 1'b1, 5'd9,  32'h80001004);
    st1  = ex_bus(32'hBFC0001C, 1'b1, 4'hF, 1'b0, 1'b0, 5'd3,  32'hA5A5A5A5);
    ld3  = ex_bus(32'hBFC00020, 1'b1, 4'h0, 1'b1, 1'b1, 5'd10, 32'h80001008);
    alu2 = ex_bus(32'hBFC00024, 1'b0, 4'h0, 1'b0, 1'b1, 5'd4,  32'h0BADCAFE);
    alu3 = ex_bus(32'hBFC00028, 1'b0, 4'h0, 1'b0, 1'b1, 5'd6,  32'h600DF00D);
    ld4  = ex_bus(32'hBFC0002C, 1'b1, 4'h0, 1'b1, 1'b1, 5'd11, 32'h8000100C);
    ld5  = ex_bus(32'hBFC00030, 1'b1, 4'h0, 1'b1, 1'b1, 5'd12, 32'h80001010);
    alu4 = ex_bus(32'hBFC00034, 1'b0, 4'h0, 1'b0, 1'b1, 5'd7,  32'h13572468);

    repeat (2) @(posedge clk);

    step(1'b0, 1'b0, ST_RUN, alu1, 32'h0, "reset_state", '0, 1'b0);
    step(1'b0, 1'b0, ST_RUN, ld1, 32'h0, "alu_pass",
         wb_bus(32'hBFC00010, 1'b1, 5'd5, 32'h12345678), 1'b0);
    step(1'b0, 1'b0, ST_RUN, ld2, 32'hDEADBEEF, "load_fresh",
         wb_bus(32'hBFC00014, 1'b1, 5'd8, 32'hDEADBEEF), 1'b0);
    step(1'b0, 1'b0, ST_RUN, st1, 32'h11112222, "load_b2b",
         wb_bus(32'hBFC00018, 1'b1, 5'd9, 32'h11112222), 1'b0);
    step(1'b0, 1'b0, ST_RUN, ld3, 32'hFFFFFFFF, "store_pass",
         wb_bus(32'hBFC0001C, 1'b0, 5'd3, 32'hA5A5A5A5), 1'b0);

    // Load held for three stalled edges; SRAM data is garbage after the first MEM cycle.
    step(1'b0, 1'b0, ST_HOLD, alu2, 32'hCAFEF00D, "held_c1",
         wb_bus(32'hBFC00020, 1'b1, 5'd10, 32'hCAFEF00D), 1'b0);
    step(1'b0, 1'b0, ST_HOLD, alu2, 32'h0, "held_c2",
         wb_bus(32'hBFC00020, 1'b1, 5'd10, 32'hCAFEF00D), 1'b1);
    step(1'b0, 1'b0, ST_HOLD, alu2, 32'h0, "held_c3",
         wb_bus(32'hBFC00020, 1'b1, 5'd10, 32'hCAFEF00D), 1'b1);
    step(1'b0, 1'b0, ST_RUN, alu2, 32'h0, "held_c4",
         wb_bus(32'hBFC00020, 1'b1, 5'd10, 32'hCAFEF00D), 1'b1);
    step(1'b0, 1'b0, ST_BUB, alu3, 32'h0, "after_hold",
         wb_bus(32'hBFC00024, 1'b1, 5'd4, 32'h0BADCAFE), 1'b0);

    step(1'b0, 1'b0, ST_RUN, alu3, 32'h0, "bubble", '0, 1'b0);
    step(1'b0, 1'b0, ST_RUN, ld4, 32'h0, "bubble_recover",
         wb_bus(32'hBFC00028, 1'b1, 5'd6, 32'h600DF00D), 1'b0);

    step(1'b0, 1'b0, ST_HOLD, ld5, 32'h55AA55AA, "flush_pre",
         wb_bus(32'hBFC0002C, 1'b1, 5'd11, 32'h55AA55AA), 1'b0);
    step(1'b0, 1'b1, ST_HOLD, ld5, 32'h0, "flush_held",
         wb_bus(32'hBFC0002C, 1'b1, 5'd11, 32'h55AA55AA), 1'b1);
    step(1'b0, 1'b0, ST_RUN, ld5, 32'h0, "flush_clear", '0, 1'b0);
    step(1'b0, 1'b0, ST_HOLD, alu4, 32'h77778888, "post_flush_live",
         wb_bus(32'hBFC00030, 1'b1, 5'd12, 32'h77778888), 1'b0);
    step(1'b0, 1'b0, ST_HOLD, alu4, 32'h0, "rst_pre",
         wb_bus(32'hBFC00030, 1'b1, 5'd12, 32'h77778888), 1'b1);

    // Reset raised mid-cycle during a held load must clear the outputs before the next edge.
    step(1'b1, 1'b0, ST_HOLD, alu4, 32'h0, "rst_mid", '0, 1'b0);
    step(1'b0, 1'b1, ST_RUN, alu4, 32'h0, "rst_release", '0, 1'b0);
    step(1'b0, 1'b0, ST_RUN, alu4, 32'h0, "flush_blocks_input", '0, 1'b0);
    step(1'b0, 1'b0, ST_RUN, '0, 32'h0, "post_flush_capture",
         wb_bus(32'hBFC00034, 1'b1, 5'd7, 32'h13572468), 1'b0);

    @(posedge clk);
    @(negedge clk);
    #1;
    n_checks++;
    if (sb.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain actual=%0d expected=0", sb.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access pipeline stage, sits between the execute stage and the write-back stage.
- Registers the execute-to-memory bus and merges the data-SRAM read data for loads.
- Produces the memory-to-writeback bus.
- Holds the load data in a local buffer while the stage is stalled, so a stalled load does not lose its synchronous-SRAM read data.

Parameters:
- STALL_W, 6, width of the pipeline stall vector; bit 3 = this stage, bit 4 = write-back stage
- EX_TO_MEM_WD, 76, input bus width: {pc[75:44], data_ram_en[43], data_ram_wen[42:39], sel_rf_res[38], rf_we[37], rf_waddr[36:32], ex_result[31:0]}
- MEM_TO_WB_WD, 70, output bus width: {pc[69:38], rf_we[37], rf_waddr[36:32], rf_wdata[31:0]}

Ports:
- clk  in  1  core clock, rising edge
- rst  in  1  asynchronous, active-high reset
- flush  in  1  pipeline flush; clears the stage register
- stall  in  STALL_W  stall vector, 1 = Stop
- ex_to_mem_bus  in  EX_TO_MEM_WD  execute-stage result bus
- data_sram_rdata  in  32  data SRAM read data; valid the cycle after the request (the first cycle the load sits in this stage)
- mem_to_wb_bus  out  MEM_TO_WB_WD  write-back bus
- mem_busy  out  1  a held load is being served from the buffer (debug/observe)

Behaviour:
- Stage register bus_r (EX_TO_MEM_WD), updated on the rising clk edge. Priority order:
  - rst: bus_r = 0, async.
  - flush: bus_r = 0.
  - stall[3]=1 and stall[4]=0: bus_r = 0 (bubble into MEM).
  - stall[3]=0: bus_r = ex_to_mem_bus.
  - Otherwise: hold.
- Field decode of bus_r follows the parameter layout exactly. The all-zero bus means no write (rf_we=0).
- Load detect: is_load = data_ram_en & (data_ram_wen == 4'b0) & sel_rf_res.
- FSM, 2 states:
  - FRESH: the instruction arrived in MEM this cycle. Load data = data_sram_rdata.
  - HELD: the instruction stayed in MEM from a previous cycle. Load data = rdata_buf.
- FRESH→HELD:
  - Condition: clock edge where bus_r holds (no rst, no flush, stall[3]=1 and stall[4]=1) and is_load=1.
  - Action: on that same edge, rdata_buf captures data_sram_rdata.
- HELD→HELD: the hold continues; rdata_buf is not rewritten.
- HELD→FRESH: any edge where bus_r is rewritten (new instruction, bubble or flush).
- rst: state = FRESH, rdata_buf = 0, async.
- mem_busy = 1 exactly when state is HELD.
- Result mux:
  - rf_wdata = load data when sel_rf_res=1, otherwise ex_result.
  - Output is combinational from bus_r, state and rdata_buf, so rf_wdata is valid in the same cycle the instruction is in MEM.
- mem_to_wb_bus = {pc, rf_we, rf_waddr, rf_wdata}. All fields are 0 after reset, flush or bubble.
- Stores (data_ram_wen ≠ 0) pass ex_result through unchanged. rf_we comes from the bus (0 for stores).
- Latency: 1 cycle from ex_to_mem_bus capture to a valid mem_to_wb_bus.
- Boundary cases:
  - Flush during HELD: bus_r = 0 and state = FRESH on the same edge; the buffered data is discarded.
  - rst mid-stall: everything clears immediately. No load data survives reset.
  - Back-to-back loads with no stall: each load uses the live data_sram_rdata; the buffer is never written.

Optional Feature:
- Macro: MEM_FWD_EN.
- Defined: adds outputs mem_fwd_we (1), mem_fwd_waddr (5), mem_fwd_wdata (32) to the decode stage.
  - Combinationally equal to this stage's rf_we, rf_waddr, rf_wdata.
  - Forced to 0 while bus_r is a bubble.
  - Lets decode bypass the MEM result, including load data from the buffer when HELD.
- Not defined: no extra ports, no forwarding logic. Decode must stall on MEM-stage hazards.

Test Plan:
- Reset/flush: assert rst mid-cycle with bus_r nonzero → mem_to_wb_bus = 0 immediately, mem_busy = 0. After release, flush=1 with valid input → bus stays 0.
- ALU pass-through: bus pc=0xBFC00010, rf_we=1, waddr=5, ex_result=0x12345678, sel_rf_res=0 → next cycle mem_to_wb_bus = {0xBFC00010, 1, 5, 0x12345678}.
- Load, no stall: load to waddr=8, data_sram_rdata=0xDEADBEEF in the MEM cycle → rf_wdata = 0xDEADBEEF, mem_busy = 0.
- Load held 3 cycles:
  - Stimulus: stall[4:3]=2'b11 for 3 cycles; data_sram_rdata=0xCAFEF00D in the first MEM cycle, then 0x0 garbage.
  - Response: rf_wdata = 0xCAFEF00D in all 4 cycles; mem_busy = 1 in cycles 2–4.
- Bubble insertion: stall[4:3]=2'b01 → next cycle bus all zero. The following cycle with stall clear captures the new input.
- Flush while HELD: flush=1 during a held load → next cycle bus = 0, mem_busy = 0. The next load reads live data_sram_rdata, not the stale buffer.
